elevator_request_scheduler: RTL

Collects per-floor call buttons into a pending-request register and sequences the elevator car through them with a SCAN (collective) policy. It drives `elevator_state_machine.requested_floor` through `target_floor` and watches `current_floor` and `idle_display` for arrival. On arrival it holds the door open for a fixed dwell, clears the served request, then issues the next target. It sits between the `ui_in` button inputs and the elevator FSM inside `tt_um_example`.

---
 rtl/elevator_request_scheduler.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : elevator_request_scheduler                                 |
// | Description : Latches per-floor call buttons into a pending-request      |
// |               register and walks the car through them with a SCAN       |
// |               (collective) policy. Issues target_floor to the elevator   |
// |               FSM, detects arrival, holds the door for a fixed dwell,    |
// |               clears the served request and issues the next target.      |
// | Option      : define SCHED_PASSBY_EN to retarget while travelling so the |
// |               car stops at intermediate calls in its travel direction.   |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               call_req[NUM_FLOORS]  level call buttons, bit i = floor i  |
// |               current_floor[4]      car position from the elevator FSM   |
// |               car_idle              elevator FSM idle indication         |
// |               target_floor[4]       registered floor request             |
// |               pending[NUM_FLOORS]   registered request lamps             |
// |               dir_up                sweep direction, 1 = up              |
// |               door_open             high while dwelling at a floor       |
// |               busy                  not idle or requests outstanding     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS  = 6,
    parameter logic [31:0] DWELL_COUNT = 32'd20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [31:0] c_dwell_last = DWELL_COUNT - 32'd1;
    localparam logic [3:0]  c_num_floors = 4'(NUM_FLOORS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q,        state_d;
    logic [3:0]              target_floor_q, target_floor_d;
    logic [NUM_FLOORS-1:0]   pending_q,      pending_d;
    logic                    dir_up_q,       dir_up_d;
    logic                    door_open_q,    door_open_d;
    logic [31:0]             dwell_cnt_q,    dwell_cnt_d;

    // ------------------------------------------------------------------
    // Current-floor decode
    // ------------------------------------------------------------------
    logic                  w_cf_valid;
    logic [NUM_FLOORS-1:0] w_cf_onehot;
    logic                  w_pend_at_cf;
    logic                  w_press_at_cf;
    logic                  w_any_pending;
    logic [NUM_FLOORS-1:0] w_clear_mask;

    assign w_cf_valid = (current_floor < c_num_floors);
    // An out-of-range floor shifts the single bit out entirely, so the
    // one-hot is zero and neither clears nor restarts can occur.
    assign w_cf_onehot   = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << current_floor;
    assign w_pend_at_cf  = |(pending_q & w_cf_onehot);
    assign w_press_at_cf = |(call_req & w_cf_onehot);
    assign w_any_pending = |pending_q;

    // ------------------------------------------------------------------
    // SCAN selection over the registered request lamps
    // ------------------------------------------------------------------
    logic       w_up_found, w_dn_found;
    logic [3:0] w_up_pick,  w_dn_pick;
    logic [3:0] w_sel_floor;
    logic       w_sel_dir_up;

    always_comb begin
        w_up_found = 1'b0;
        w_up_pick  = 4'd0;
        w_dn_found = 1'b0;
        w_dn_pick  = 4'd0;
        // Descending scan: the last hit is the lowest floor at or above cf.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (4'(i) >= current_floor)) begin
                w_up_found = 1'b1;
                w_up_pick  = 4'(i);
            end
        end
        // Ascending scan: the last hit is the highest floor at or below cf.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (4'(i) <= current_floor)) begin
                w_dn_found = 1'b1;
                w_dn_pick  = 4'(i);
            end
        end
    end

    // Keep sweeping in the current direction while calls remain ahead;
    // otherwise reverse and take the nearest call behind the car.
    always_comb begin
        w_sel_floor  = target_floor_q;
        w_sel_dir_up = dir_up_q;
        if (dir_up_q) begin
            if (w_up_found) begin
                w_sel_floor  = w_up_pick;
                w_sel_dir_up = 1'b1;
            end else begin
                w_sel_floor  = w_dn_pick;
                w_sel_dir_up = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                w_sel_floor  = w_dn_pick;
                w_sel_dir_up = 1'b0;
            end else begin
                w_sel_floor  = w_up_pick;
                w_sel_dir_up = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        dir_up_d       = dir_up_q;
        dwell_cnt_d    = dwell_cnt_q;
        w_clear_mask   = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_cf_valid) begin
                    if (w_pend_at_cf) begin
                        // Call at the car's own floor: open without moving.
                        state_d      = ST_DWELL;
                        dwell_cnt_d  = 32'd0;
                        w_clear_mask = w_cf_onehot;
                    end else if (w_any_pending) begin
                        state_d        = ST_SERVE;
                        target_floor_d = w_sel_floor;
                        dir_up_d       = w_sel_dir_up;
                    end
                end
            end

            ST_SERVE: begin
                if (w_cf_valid) begin
                    // Requiring the floor match rejects a stale idle flag
                    // that is still asserted before the car departs.
                    if (car_idle && (current_floor == target_floor_q)) begin
                        state_d      = ST_DWELL;
                        dwell_cnt_d  = 32'd0;
                        w_clear_mask = w_cf_onehot;
                    end
`ifdef SCHED_PASSBY_EN
                    // Direction is held while travelling; only a nearer
                    // call ahead of the car can replace the target.
                    else if (dir_up_q && w_up_found) begin
                        target_floor_d = w_up_pick;
                    end else if (!dir_up_q && w_dn_found) begin
                        target_floor_d = w_dn_pick;
                    end
`endif
                end
            end

            ST_DWELL: begin
                // Presses at the open floor are swallowed for the whole dwell.
                w_clear_mask = w_cf_onehot;
                if (w_cf_valid) begin
                    if (w_press_at_cf) begin
                        dwell_cnt_d = 32'd0;
                    end else if (dwell_cnt_q == c_dwell_last) begin
                        dwell_cnt_d = 32'd0;
                        if (w_any_pending) begin
                            state_d        = ST_SERVE;
                            target_floor_d = w_sel_floor;
                            dir_up_d       = w_sel_dir_up;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 32'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear wins over a same-cycle press of the same floor.
        pending_d   = (pending_q | call_req) & ~w_clear_mask;
        door_open_d = (state_d == ST_DWELL);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            target_floor_q <= 4'd0;
            pending_q      <= '0;
            dir_up_q       <= 1'b1;
            door_open_q    <= 1'b0;
            dwell_cnt_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            target_floor_q <= target_floor_d;
            pending_q      <= pending_d;
            dir_up_q       <= dir_up_d;
            door_open_q    <= door_open_d;
            dwell_cnt_q    <= dwell_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign target_floor = target_floor_q;
    assign pending      = pending_q;
    assign dir_up       = dir_up_q;
    assign door_open    = door_open_q;
    assign busy         = (state_q != ST_IDLE) | (|pending_q);

endmodule
`default_nettype wire
